// File: rtl/esb_pkg.sv
// Shared defaults and derived widths for exposure_stream_buffer.
package esb_pkg;

  localparam int CH_DEF         = 3;
  localparam int WORD_W_DEF     = 128;
  localparam int PIX_W_DEF      = 16;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int LANES          = WORD_W_DEF / PIX_W_DEF;
  localparam int UNDERRUN_W     = 16;

  // Counter width for n states, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LANE_W = cnt_width(LANES);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO holding one full multi-channel word set per entry.
module sync_fifo
  import esb_pkg::*;
#(
  parameter int W          = 8,
  parameter int DEPTH_LOG2 = 4
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [W-1:0]          mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  do_wr_s;
  logic                  do_rd_s;

  assign empty   = (count_r == '0);
  assign do_wr_s = wr_en && (count_r != CNT_FULL) && !flush;
  assign do_rd_s = rd_en && !empty && !flush;
  assign rd_data = mem_r[rd_ptr_r];

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Shared pointers and occupancy; pointers wrap through their natural width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_wr_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_rd_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/exposure_stream_buffer.sv
// Channel-aligned word FIFO unpacked into a gapless pixel stream.
// Optional ESB_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module exposure_stream_buffer
  import esb_pkg::*;
#(
  parameter int CH         = CH_DEF,
  parameter int WORD_W     = WORD_W_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
)(
  input  logic                   clk_25M,
  input  logic                   rst_n_25M,
  input  logic [CH*WORD_W-1:0]   wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   flush,
  input  logic                   clr_ovf,
  output logic [CH*PIX_W-1:0]    pix_data,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [DEPTH_LOG2:0]    level,
  output logic                   overflow
`ifdef ESB_UNDERRUN_CNT_EN
  ,
  output logic [UNDERRUN_W-1:0]  underrun_cnt
`endif
);

  localparam int N_LANES = WORD_W / PIX_W;
  localparam int LW      = cnt_width(N_LANES);
  localparam logic [LW-1:0]         LAST_LANE = LW'(N_LANES - 1);
  localparam logic [LW-1:0]         LANE_ONE  = LW'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL  = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2 + 1)'(1);

  logic [CH*WORD_W-1:0] word_r;
  logic [CH*WORD_W-1:0] shifted_s;
  logic [CH*WORD_W-1:0] fifo_rd_s;
  logic                 valid_r;
  logic [LW-1:0]        lane_r;
  logic [DEPTH_LOG2:0]  level_r;
  logic                 ovf_r;
  logic fifo_empty_s, wr_acc_s, accept_s, retire_s, load_s;
  logic from_fifo_s, bypass_s, fifo_wr_s;

  // Level counts every buffered word, including the one being unpacked.
  assign wr_ready    = (level_r != LVL_FULL);
  assign wr_acc_s    = wr_valid && wr_ready && !flush;
  assign accept_s    = valid_r && pix_ready;
  assign retire_s    = accept_s && (lane_r == LAST_LANE);
  assign load_s      = !valid_r || retire_s;
  assign from_fifo_s = load_s && !fifo_empty_s && !flush;
  assign bypass_s    = load_s && fifo_empty_s && wr_acc_s;
  assign fifo_wr_s   = wr_acc_s && !bypass_s;

  assign pix_valid = valid_r;
  assign level     = level_r;
  assign overflow  = ovf_r;

  sync_fifo #(
    .W          (CH * WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk_25M),
    .rst_n   (rst_n_25M),
    .flush   (flush),
    .wr_en   (fifo_wr_s),
    .wr_data (wr_data),
    .rd_en   (from_fifo_s),
    .rd_data (fifo_rd_s),
    .empty   (fifo_empty_s)
  );

  // Each channel shifts down one pixel per accepted lane, so lane 0 of the register is always current.
  always_comb begin
    shifted_s = '0;
    pix_data  = '0;
    for (int c = 0; c < CH; c++) begin
      shifted_s[c*WORD_W +: WORD_W] = word_r[c*WORD_W +: WORD_W] >> PIX_W;
      pix_data[c*PIX_W +: PIX_W]    = word_r[c*WORD_W +: PIX_W];
    end
  end

  // Output word register and lane counter.
  always_ff @(posedge clk_25M or negedge rst_n_25M) begin
    if (!rst_n_25M) begin
      word_r  <= '0;
      valid_r <= 1'b0;
      lane_r  <= '0;
    end else if (flush) begin
      word_r  <= '0;
      valid_r <= 1'b0;
      lane_r  <= '0;
    end else if (from_fifo_s) begin
      word_r  <= fifo_rd_s;
      valid_r <= 1'b1;
      lane_r  <= '0;
    end else if (bypass_s) begin
      word_r  <= wr_data;
      valid_r <= 1'b1;
      lane_r  <= '0;
    end else if (accept_s) begin
      word_r  <= shifted_s;
      valid_r <= !retire_s;
      lane_r  <= retire_s ? '0 : lane_r + LANE_ONE;
    end else begin
      word_r  <= word_r;
      valid_r <= valid_r;
      lane_r  <= lane_r;
    end
  end

  // Occupancy and sticky overflow; a set outranks a same-cycle clear.
  always_ff @(posedge clk_25M or negedge rst_n_25M) begin
    if (!rst_n_25M) begin
      level_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      if (flush) begin
        level_r <= '0;
      end else begin
        case ({wr_acc_s, retire_s})
          2'b10:   level_r <= level_r + LVL_ONE;
          2'b01:   level_r <= level_r - LVL_ONE;
          default: level_r <= level_r;
        endcase
      end
      if (wr_valid && !wr_ready) ovf_r <= 1'b1;
      else if (clr_ovf)          ovf_r <= 1'b0;
      else                       ovf_r <= ovf_r;
    end
  end

`ifdef ESB_UNDERRUN_CNT_EN
  logic [UNDERRUN_W-1:0] ur_cnt_r;
  assign underrun_cnt = ur_cnt_r;

  // Cycles where downstream wanted a pixel but none was available.
  always_ff @(posedge clk_25M or negedge rst_n_25M) begin
    if (!rst_n_25M) begin
      ur_cnt_r <= '0;
    end else if (flush) begin
      ur_cnt_r <= '0;
    end else if (pix_ready && !valid_r && (ur_cnt_r != 16'hFFFF)) begin
      ur_cnt_r <= ur_cnt_r + 16'd1;
    end else begin
      ur_cnt_r <= ur_cnt_r;
    end
  end
`endif

endmodule

// File: doc/exposure_stream_buffer.md
EXPOSURE_STREAM_BUFFER -- requirements
Module: exposure_stream_buffer

Interface
REQ-001 SHALL have parameter CH, default 3: number of exposure channels (high/mid/low), range 1..8.
REQ-002 SHALL have parameter WORD_W, default 128: memory word width per channel.
REQ-003 SHALL have parameter PIX_W, default 16: pixel width; WORD_W SHALL be an integer multiple of PIX_W.
REQ-004 SHALL have parameter DEPTH_LOG2, default 4: FIFO depth 2**DEPTH_LOG2 words.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 Ports:
- clk_25M  in  1  sole clock, all logic on rising edge
- rst_n_25M  in  1  asynchronous active-low reset
- wr_data  in  CH*WORD_W  one word per channel; channel c at [c*WORD_W +: WORD_W]
- wr_valid  in  1  word set presented
- wr_ready  out  1  FIFO can accept
- flush  in  1  synchronous clear of all buffered data
- clr_ovf  in  1  clears overflow flag
- pix_data  out  CH*PIX_W  current pixel per channel; channel c at [c*PIX_W +: PIX_W]
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts pixel
- level  out  DEPTH_LOG2+1  FIFO occupancy in words
- overflow  out  1  sticky: write attempted while full

Function
REQ-007 SHALL store all CH words of a write as one entry under a single shared write/read pointer pair, keeping channels aligned by construction.
REQ-008 SHALL accept a write when wr_valid && wr_ready; wr_ready = (level != 2**DEPTH_LOG2), from registered state only.
REQ-009 SHALL hold the current word set in an output register with lane counter 0..WORD_W/PIX_W-1; lane k drives bits [k*PIX_W +: PIX_W] of each channel, lane 0 first.
REQ-010 SHALL pop the FIFO into the output register when the register is empty, or when the last lane is accepted (pix_valid && pix_ready) in that cycle with the FIFO non-empty, giving gapless output across words.
REQ-011 SHALL assert pix_valid the cycle after a word is written into an empty buffer (latency 1).
REQ-012 SHALL advance the lane counter only on pix_valid && pix_ready, wrapping to 0 after the last lane.
REQ-013 SHALL hold pix_data and pix_valid stable while pix_valid && !pix_ready.
REQ-014 SHALL deassert pix_valid after the last lane is accepted with the FIFO empty.
REQ-015 Simultaneous write and pop SHALL leave level unchanged; pointers SHALL wrap modulo 2**DEPTH_LOG2.
REQ-016 SHALL set overflow when wr_valid && !wr_ready, discarding the write; clr_ovf clears it, set wins if both in the same cycle.
REQ-017 flush SHALL empty the FIFO and output register and zero the lane counter next cycle; a write in the flush cycle SHALL be discarded; overflow unaffected.

Reset
REQ-018 On rst_n_25M low: pointers, level, lane counter 0; pix_valid 0; overflow 0; pix_data 0; wr_ready 1 after release.
REQ-019 Reset asserted mid-stream SHALL discard all buffered data immediately; no pix_valid until a new write.

Configuration
REQ-020 With ESB_UNDERRUN_CNT_EN defined: extra output underrun_cnt, 16 bits, counts cycles with pix_ready && !pix_valid, saturating at 0xFFFF, cleared by reset and flush.
REQ-021 Without ESB_UNDERRUN_CNT_EN: port and counter absent; all other behaviour identical.

Structure
REQ-022 Package esb_pkg SHALL hold default CH/WORD_W/PIX_W/DEPTH_LOG2 and derived LANES = WORD_W/PIX_W plus lane-counter width.
REQ-023 Storage and pointers SHALL be one sub-module sync_fifo (width CH*WORD_W, depth parameter, single clock); lane unpacking stays in the top.

Verification (CH=3, WORD_W=128, PIX_W=16, DEPTH_LOG2=4)
REQ-024 One write, channel c lane k = 16'h{c}{k}00, pix_ready=1 -> pix_valid from next cycle for exactly 8 cycles, lanes 0..7 in order, channels aligned.
REQ-025 17 writes with pix_ready=0 -> level 16, wr_ready 0 after 16th, overflow 1; clr_ovf -> overflow 0.
REQ-026 4 back-to-back writes, pix_ready=1 -> 32 consecutive pix_valid cycles, no bubble at word boundaries.
REQ-027 pix_ready toggled 1,0,0,1 during a word -> pix_data held during stall, no lane skipped or repeated.
REQ-028 flush concurrent with a write, level 5 -> level 0, pix_valid 0 next cycle, flushed write absent.
REQ-029 rst_n_25M pulsed low mid-word -> pix_valid 0 immediately, level 0; with ESB_UNDERRUN_CNT_EN, 10 idle cycles with pix_ready=1 -> underrun_cnt 10.
